// File: rtl/decode_pkg.sv
// Shared opcode map, control-field struct and sign-extension helper for the decode stage.
package decode_pkg;

  localparam logic [3:0] OPC_NOP    = 4'd0;
  localparam logic [3:0] OPC_ALU_LO = 4'd1;
  localparam logic [3:0] OPC_ALU_HI = 4'd8;
  localparam logic [3:0] OPC_ADDI   = 4'd9;
  localparam logic [3:0] OPC_LD     = 4'd10;
  localparam logic [3:0] OPC_ST     = 4'd11;
  localparam logic [3:0] OPC_BZ     = 4'd12;

  localparam logic [2:0] ALU_CMD_ADD = 3'd0;

  // Width-independent part of the execute bundle; the data/address fields are
  // sized by the instantiating module's parameters.
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] alu_cmd;
    logic       mem_we;
    logic       wb_mux;
    logic       wb_en;
  } ctrl_t;

  // Sign-extends the low w bits of v to 64 bits; callers cast down to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return $unsigned(t >>> (64 - w));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file and execute-side signals of the decode stage in one bundle.
interface decode_stage_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 6,
  parameter int INSTR_W = 16
);
  // Both handshakes: a transfer happens on a rising clk edge where valid && ready;
  // the producer holds valid and its payload stable until that edge.
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [REG_AW-1:0]  rs1_addr;
  logic [REG_AW-1:0]  rs2_addr;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic               branch_taken;
  logic [IMM_W-1:0]   branch_offset;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_opcode;
  logic [2:0]         out_alu_cmd;
  logic [DATA_W-1:0]  out_a;
  logic [DATA_W-1:0]  out_b;
  logic [DATA_W-1:0]  out_store_data;
  logic [REG_AW-1:0]  out_dest;
  logic [REG_AW-1:0]  out_src1;
  logic [REG_AW-1:0]  out_src2;
  logic               out_mem_we;
  logic               out_wb_mux;
  logic               out_wb_en;
  logic               illegal_op;

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, branch_taken, branch_offset,
           out_valid, out_opcode, out_alu_cmd, out_a, out_b, out_store_data,
           out_dest, out_src1, out_src2, out_mem_we, out_wb_mux, out_wb_en, illegal_op
  );

  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, branch_taken, branch_offset,
           out_valid, out_opcode, out_alu_cmd, out_a, out_b, out_store_data,
           out_dest, out_src1, out_src2, out_mem_we, out_wb_mux, out_wb_en, illegal_op
  );
endinterface

// File: rtl/decode_hazard_unit.sv
// Load-use detector: flags an instruction that reads the destination of a load still
// sitting in the execute register. Only built when DECODE_HAZARD_EN is defined.
`ifdef DECODE_HAZARD_EN
module decode_hazard_unit
  import decode_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              out_valid,
  input  logic [3:0]        out_opcode,
  input  logic [REG_AW-1:0] out_dest,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  output logic              hazard
);
  logic uses_src1;
  logic uses_src2;

  assign uses_src1 = (opcode != OPC_NOP) && (opcode <= OPC_BZ);
  assign uses_src2 = ((opcode >= OPC_ALU_LO) && (opcode <= OPC_ALU_HI)) || (opcode == OPC_ST);

  // r0 never carries a real dependency, so a load to r0 does not interlock.
  assign hazard = out_valid && (out_opcode == OPC_LD) && (out_dest != '0) &&
                  ((uses_src1 && (src1 == out_dest)) || (uses_src2 && (src2 == out_dest)));
endmodule
`endif

// File: rtl/decode_stage.sv
// In-order decode stage: operand read, BZ resolution, registered execute bundle.
// Define DECODE_HAZARD_EN to build the load-use interlock; otherwise hazard is tied low.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 6,
  parameter int INSTR_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);
  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
  } bundle_t;

  logic [3:0]        opc;
  logic [REG_AW-1:0] rd, rs1, rs2, rs2_sel;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  logic              is_alu, is_illegal;
  logic              hazard, advance, in_ready, accept;
  logic              produces;
  bundle_t           nxt, bundle_q;
  logic              out_valid_q, illegal_q;

  assign opc     = bus.instr[INSTR_W-1 -: 4];
  assign rd      = bus.instr[INSTR_W-5 -: REG_AW];
  assign rs1     = bus.instr[INSTR_W-5-REG_AW -: REG_AW];
  assign rs2     = bus.instr[INSTR_W-5-2*REG_AW -: REG_AW];
  assign imm     = bus.instr[IMM_W-1:0];
  assign imm_ext = DATA_W'(sext(64'(imm), IMM_W));

  assign is_alu     = (opc >= OPC_ALU_LO) && (opc <= OPC_ALU_HI);
  assign is_illegal = (opc > OPC_BZ);

  // Stores read their data register through the second port via the rd field.
  assign rs2_sel      = (opc == OPC_ST) ? rd : rs2;
  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2_sel;

`ifdef DECODE_HAZARD_EN
  decode_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .out_valid  (out_valid_q),
    .out_opcode (bundle_q.ctrl.opcode),
    .out_dest   (bundle_q.dest),
    .opcode     (opc),
    .src1       (rs1),
    .src2       (rs2_sel),
    .hazard     (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  assign advance      = !out_valid_q || bus.out_ready;
  assign in_ready     = advance && !hazard;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // Gated by accept, so a hazard-stalled BZ never redirects fetch on a stale operand.
  assign bus.branch_taken  = accept && (opc == OPC_BZ) && (bus.rs1_data == '0);
  assign bus.branch_offset = imm;

  always_comb begin
    nxt             = '0;
    produces        = 1'b0;
    nxt.ctrl.opcode = opc;
    nxt.a           = bus.rs1_data;
    nxt.src1        = rs1;
    nxt.dest        = rd;
    if (is_alu) begin
      produces         = 1'b1;
      nxt.ctrl.alu_cmd = 3'(opc - OPC_ALU_LO);
      nxt.b            = bus.rs2_data;
      nxt.src2         = rs2_sel;
      nxt.ctrl.wb_en   = 1'b1;
    end else if ((opc == OPC_ADDI) || (opc == OPC_LD)) begin
      produces         = 1'b1;
      nxt.ctrl.alu_cmd = ALU_CMD_ADD;
      nxt.b            = imm_ext;
      nxt.ctrl.wb_en   = 1'b1;
      nxt.ctrl.wb_mux  = (opc == OPC_LD);
    end else if (opc == OPC_ST) begin
      produces         = 1'b1;
      nxt.ctrl.alu_cmd = ALU_CMD_ADD;
      nxt.b            = imm_ext;
      nxt.store_data   = bus.rs2_data;
      nxt.src2         = rs2_sel;
      nxt.dest         = '0;
      nxt.ctrl.mem_we  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      bundle_q    <= '0;
    end else begin
      illegal_q <= accept && is_illegal;
      // With hazard high the register advances with accept low: that is the bubble.
      if (advance) begin
        out_valid_q <= accept && produces;
        if (accept && produces) bundle_q <= nxt;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.illegal_op     = illegal_q;
  assign bus.out_opcode     = bundle_q.ctrl.opcode;
  assign bus.out_alu_cmd    = bundle_q.ctrl.alu_cmd;
  assign bus.out_mem_we     = bundle_q.ctrl.mem_we;
  assign bus.out_wb_mux     = bundle_q.ctrl.wb_mux;
  assign bus.out_wb_en      = bundle_q.ctrl.wb_en;
  assign bus.out_a          = bundle_q.a;
  assign bus.out_b          = bundle_q.b;
  assign bus.out_store_data = bundle_q.store_data;
  assign bus.out_dest       = bundle_q.dest;
  assign bus.out_src1       = bundle_q.src1;
  assign bus.out_src2       = bundle_q.src2;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model with an expected queue.
module tb_decode_stage;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int IW = 6;
  localparam int NW = 16;
`ifdef DECODE_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]    opc;
    logic [2:0]    alu;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sd;
    logic [AW-1:0] dest;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic          we;
    logic          mux;
    logic          en;
  } bnd_t;
  localparam int BW = $bits(bnd_t);

  typedef struct {
    logic [NW-1:0] ins;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          ev;
    bnd_t          eb;
    logic          eill;
    logic          ebr;
    logic [AW-1:0] rs2a;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DW), .REG_AW(AW), .IMM_W(IW), .INSTR_W(NW)) bus ();
  decode_stage #(.DATA_W(DW), .REG_AW(AW), .IMM_W(IW), .INSTR_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  // register file: directed phase drives fixed data, random phase reads regs[]
  logic [DW-1:0] regs[8];
  logic          rf_mode;
  logic [DW-1:0] drv_d1, drv_d2;
  always_comb begin
    bus.rs1_data = rf_mode ? regs[bus.rs1_addr] : drv_d1;
    bus.rs2_data = rf_mode ? regs[bus.rs2_addr] : drv_d2;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk_r(input int o, input int rd, input int s1, input int s2);
    return {4'(o), 3'(rd), 3'(s1), 3'(s2), 3'b000};
  endfunction

  function automatic logic [NW-1:0] mk_i(input int o, input int rd, input int s1, input logic [5:0] imm);
    return {4'(o), 3'(rd), 3'(s1), imm};
  endfunction

  function automatic bnd_t mkb(input int o, input int alu, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] sd, input int dest, input int s1, input int s2,
                               input bit we, input bit mux, input bit en);
    return {4'(o), 3'(alu), a, b, sd, 3'(dest), 3'(s1), 3'(s2), we, mux, en};
  endfunction

  function automatic bnd_t act_b();
    return {bus.out_opcode, bus.out_alu_cmd, bus.out_a, bus.out_b, bus.out_store_data,
            bus.out_dest, bus.out_src1, bus.out_src2, bus.out_mem_we, bus.out_wb_mux, bus.out_wb_en};
  endfunction

  // Reference decode from the instruction-set rules; r2v is whatever the second read port sees.
  function automatic bnd_t ref_decode(input logic [NW-1:0] ins, input logic [DW-1:0] r1v,
                                      input logic [DW-1:0] r2v, output bit makes);
    bnd_t          r;
    int            o;
    logic [DW-1:0] sx;
    o  = int'(ins[15:12]);
    sx = 16'($signed(ins[5:0]));
    r = '0;
    r.opc = ins[15:12];
    makes = 1'b1;
    if (o >= 1 && o <= 8)
      r = mkb(o, o - 1, r1v, r2v, 16'h0, int'(ins[11:9]), int'(ins[8:6]), int'(ins[5:3]), 0, 0, 1);
    else if (o == 9 || o == 10)
      r = mkb(o, 0, r1v, sx, 16'h0, int'(ins[11:9]), int'(ins[8:6]), 0, 0, (o == 10), 1);
    else if (o == 11)
      r = mkb(o, 0, r1v, sx, r2v, 0, int'(ins[8:6]), int'(ins[11:9]), 1, 0, 0);
    else
      makes = 1'b0;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return ($urandom_range(0, 2) == 0) ? '0 : 16'($urandom);
  endfunction

  function automatic logic [NW-1:0] rand_instr();
    int o;
    o = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(0, 15));
    return {4'(o), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_illegal", bus.illegal_op, 0);
    chk("reset_bundle", act_b(), '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          vt[12];
    int            n;
    bit            acc_seen;
    logic [NW-1:0] cur_ins;
    logic          cur_iv, cur_ordy, hold;
    bit            m_valid, m_ill, makes, haz, rdy, acc, br, uses1, uses2;
    bnd_t          m_last, nb;
    int            o;
    logic [AW-1:0] s1, rda, read2;

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    rf_mode = 1'b0;
    drv_d1 = '0;
    drv_d2 = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;

    vt[0]  = '{mk_r(1, 1, 2, 3), 16'd5, 16'd7, 1, mkb(1, 0, 16'd5, 16'd7, 0, 1, 2, 3, 0, 0, 1), 0, 0, 3'd3};
    vt[1]  = '{mk_i(9, 4, 1, 6'h3E), 16'h1234, 16'h5555, 1, mkb(9, 0, 16'h1234, 16'hFFFE, 0, 4, 1, 0, 0, 0, 1), 0, 0, 3'd7};
    vt[2]  = '{mk_r(6, 7, 5, 6), 16'hAAAA, 16'h0F0F, 1, mkb(6, 5, 16'hAAAA, 16'h0F0F, 0, 7, 5, 6, 0, 0, 1), 0, 0, 3'd6};
    vt[3]  = '{mk_i(10, 2, 1, 6'h05), 16'h0100, 16'h9999, 1, mkb(10, 0, 16'h0100, 16'h0005, 0, 2, 1, 0, 0, 1, 1), 0, 0, 3'd0};
    vt[4]  = '{mk_i(11, 3, 4, 6'h21), 16'h4000, 16'hBEEF, 1, mkb(11, 0, 16'h4000, 16'hFFE1, 16'hBEEF, 0, 4, 3, 1, 0, 0), 0, 0, 3'd3};
    vt[5]  = '{mk_r(0, 0, 0, 0), 16'h1111, 16'h2222, 0, '0, 0, 0, 3'd0};
    vt[6]  = '{mk_r(14, 1, 2, 3), 16'h1111, 16'h2222, 0, '0, 1, 0, 3'd3};
    vt[7]  = '{mk_i(12, 0, 1, 6'h05), 16'h0000, 16'h2222, 0, '0, 0, 1, 3'd0};
    vt[8]  = '{mk_i(12, 0, 1, 6'h05), 16'h0003, 16'h2222, 0, '0, 0, 0, 3'd0};
    vt[9]  = '{mk_r(8, 0, 7, 1), 16'hFFFF, 16'h0001, 1, mkb(8, 7, 16'hFFFF, 16'h0001, 0, 0, 7, 1, 0, 0, 1), 0, 0, 3'd1};
    vt[10] = '{mk_i(9, 5, 0, 6'h1F), 16'h0000, 16'h3333, 1, mkb(9, 0, 16'h0000, 16'h001F, 0, 5, 0, 0, 0, 0, 1), 0, 0, 3'd3};
    vt[11] = '{mk_i(9, 6, 3, 6'h20), 16'h0007, 16'h3333, 1, mkb(9, 0, 16'h0007, 16'hFFE0, 0, 6, 3, 0, 0, 0, 1), 0, 0, 3'd4};

    do_reset();

    // directed vectors, one instruction at a time with out_ready high
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.instr = vt[i].ins;
      drv_d1 = vt[i].d1;
      drv_d2 = vt[i].d2;
      #4;
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      chk($sformatf("vec%0d_rs2_addr", i), bus.rs2_addr, vt[i].rs2a);
      chk($sformatf("vec%0d_branch_taken", i), bus.branch_taken, vt[i].ebr);
      if (vt[i].ebr) chk($sformatf("vec%0d_branch_offset", i), bus.branch_offset, vt[i].ins[5:0]);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vt[i].ev);
      chk($sformatf("vec%0d_illegal", i), bus.illegal_op, vt[i].eill);
      if (vt[i].ev) chk($sformatf("vec%0d_bundle", i), act_b(), vt[i].eb);
    end

    // load-use: LD r2,0(r1) followed by ADD r3,r2,r2
    @(posedge clk); #1;
    drv_d1 = 16'd3;
    drv_d2 = 16'd3;
    bus.in_valid = 1'b1;
    bus.instr = mk_i(10, 2, 1, 6'h00);
    @(posedge clk); #1;
    bus.instr = mk_r(1, 3, 2, 2);
    #4;
    chk("load_use_in_ready", bus.in_ready, !HAZ_EN);
    n = 0;
    acc_seen = 1'b0;
    while (!(bus.out_valid && bus.out_opcode == 4'd1) && n < 6) begin
      if (bus.in_ready) acc_seen = 1'b1;
      @(posedge clk); #1;
      n++;
      if (acc_seen) bus.in_valid = 1'b0;
      #4;
    end
    chk("load_use_latency", n, HAZ_EN ? 2 : 1);
    chk("load_use_add_bundle", act_b(), mkb(1, 0, 16'd3, 16'd3, 0, 3, 2, 2, 0, 0, 1));

    // stall: ST held for 3 cycles with out_ready low, then released
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.instr = mk_i(11, 3, 4, 6'h21);
    drv_d1 = 16'h1111;
    drv_d2 = 16'h2222;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.instr = mk_i(9, 1, 2, 6'h01);
    drv_d1 = 16'h7777;
    drv_d2 = 16'h8888;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("stall%0d_out_valid", k), bus.out_valid, 1);
      chk($sformatf("stall%0d_in_ready", k), bus.in_ready, 0);
      chk($sformatf("stall%0d_bundle", k), act_b(), mkb(11, 0, 16'h1111, 16'hFFE1, 16'h2222, 0, 4, 3, 1, 0, 0));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #4;
    chk("release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release_next_bundle", act_b(), mkb(9, 0, 16'h7777, 16'h0001, 0, 1, 2, 0, 0, 0, 1));

    // reset asserted while a ST is stalled with another instruction held at the input
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.instr = mk_i(11, 3, 4, 6'h21);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.instr = mk_i(9, 1, 2, 6'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_stall_out_valid", bus.out_valid, 0);
    chk("rst_stall_bundle", act_b(), '0);
    chk("rst_stall_illegal", bus.illegal_op, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_stall_not_retained", bus.out_valid, 0);

    // randomized run against the reference model
    do_reset();
    rf_mode = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = rand_data();
    m_valid = 1'b0;
    m_ill = 1'b0;
    m_last = '0;
    hold = 1'b0;
    cur_iv = 1'b0;
    cur_ins = '0;
    exp_q.delete();
    for (int c = 0; c < 610; c++) begin
      @(posedge clk); #1;
      if (!hold) begin
        cur_iv = (c < 600) && ($urandom_range(0, 3) != 0);
        cur_ins = rand_instr();
      end
      cur_ordy = (c >= 600) || ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 7)] = rand_data();
      bus.in_valid = cur_iv;
      bus.instr = cur_ins;
      bus.out_ready = cur_ordy;
      #4;
      o = int'(cur_ins[15:12]);
      rda = cur_ins[11:9];
      s1 = cur_ins[8:6];
      read2 = (o == 11) ? rda : cur_ins[5:3];
      uses1 = (o >= 1 && o <= 12);
      uses2 = (o >= 1 && o <= 8) || (o == 11);
      haz = HAZ_EN && m_valid && (m_last.opc == 4'd10) && (m_last.dest != '0) &&
            ((uses1 && s1 == m_last.dest) || (uses2 && read2 == m_last.dest));
      rdy = (!m_valid || cur_ordy) && !haz;
      acc = cur_iv && rdy;
      br = acc && (o == 12) && (regs[s1] == '0);
      chk("rand_out_valid", bus.out_valid, m_valid);
      chk("rand_illegal", bus.illegal_op, m_ill);
      chk("rand_in_ready", bus.in_ready, rdy);
      chk("rand_branch_taken", bus.branch_taken, br);
      if (br) chk("rand_branch_offset", bus.branch_offset, cur_ins[5:0]);
      if (m_valid && cur_ordy) begin
        if (exp_q.size() == 0) chk("rand_queue_underflow", 1, 0);
        else chk("rand_bundle", act_b(), exp_q.pop_front());
      end
      nb = ref_decode(cur_ins, regs[s1], regs[read2], makes);
      if (!m_valid || cur_ordy) begin
        m_valid = acc && makes;
        if (acc && makes) begin
          m_last = nb;
          exp_q.push_back(nb);
        end
      end
      m_ill = acc && (o >= 13);
      hold = cur_iv && !acc;
    end
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
